ctrl_run_tracker: RTL and testbench
===================================

# ctrl_run_tracker

Synthesizable run-control responder for the SoC testbench harness; it produces the status that the control interface's wait tasks consume. It generates `init_done` after a programmable post-reset delay. It counts driver start events into `active_drv` and completion events into `passive_drv`, and reports run-busy, run-done and watchdog-timeout status. It sits between the per-agent start/done pulses and the control interface nets.

## Interface
Parameters:
- `NUM_DRV`, 8: number of driver agents reporting events; range 1..32.
- `INIT_DELAY`, 100: clock cycles from reset release to `init_done`; must be at least 1.
- `TIMEOUT`, 1_000_000: idle cycles in RUN before timeout; 0 disables the watchdog.
- `CNT_W`, 32: width of the event counters.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `drv_start`  in  NUM_DRV  one-cycle pulse per driver when its transaction starts.
- `drv_done`  in  NUM_DRV  one-cycle pulse per driver when its transaction completes.
- `clear`  in  1  synchronous soft clear of counters, outstanding bits and status; `init_done` is unaffected.
- `init_done`  out  1  high once INIT_DELAY cycles have elapsed after reset.
- `active_drv`  out  CNT_W  number of accepted starts.
- `passive_drv`  out  CNT_W  number of accepted completions.
- `run_busy`  out  1  high while `active_drv != passive_drv`.
- `run_done`  out  1  high when `active_drv == passive_drv` and both are nonzero.
- `timeout`  out  1  sticky watchdog flag.
- `proto_err`  out  1  sticky flag: start while outstanding, or done while not outstanding.

## Operation
- **Reset values:** all outputs are 0; outstanding vector is 0; state is INIT; delay counter is 0.
- **States:**
  - INIT: count to INIT_DELAY-1, then go to IDLE and set `init_done`.
  - IDLE: go to RUN on any accepted start.
  - RUN: go to DONE when next passive equals next active.
  - DONE: go to RUN on any accepted start.
  - TOUT: absorbing.
- **Events before `init_done`:** ignored, not counted, no error.
- **Outstanding bit per driver:**
  - An accepted start sets the bit.
  - An accepted done clears the bit.
  - A start while the bit is set is rejected, sets `proto_err`, and leaves the bit set.
  - A done while the bit is clear is rejected and sets `proto_err`.
- **Start and done on the same driver in the same cycle:**
  - Bit clear: both are accepted (zero-length transaction); both counters +1; bit stays clear.
  - Bit set: done is accepted and start is accepted; both counters +1; bit stays set.
- **Counter increments:** each counter increments by the popcount of its accepted events per cycle, up to NUM_DRV.
- **Saturation:** counters saturate at 2^CNT_W-1. Once either counter saturates, `proto_err` is set.
- **Watchdog:** the idle counter resets on any accepted event and counts only in RUN. When it reaches TIMEOUT, go to TOUT and set `timeout`. In TOUT, counters keep counting, and `run_busy`/`run_done` keep reflecting the counters.
- **`clear`:**
  - Effect: zero the counters, outstanding bits, `proto_err`, `timeout` and the idle counter; go to IDLE if `init_done`, otherwise stay in INIT.
  - Priority: `clear` overrides events in the same cycle, which are dropped.
- **`reset` mid-run:** returns to the reset values, and `init_done` drops to 0.

## Timing
- **Inputs:** sampled at the rising edge.
- **Outputs:** all registered, with one-cycle latency from event to counter update.
- **`run_busy`/`run_done`:** derived from the next counter values, so they change on the same edge as the counters. There is no extra lag.
- **`init_done`:** rises exactly INIT_DELAY edges after the first edge with `reset`=0.
- **`timeout`:** rises on the edge where the idle count equals TIMEOUT, i.e. after TIMEOUT event-free cycles in RUN.

## Structure
- **Package `ctrl_run_pkg`:**
  - state enum `run_state_e` {INIT, IDLE, RUN, DONE, TOUT};
  - popcount function;
  - default parameter constants.
- **Sub-module `ctrl_evt_popcnt`:** combinational popcount of the accepted-event vector, instantiated twice (start and done).
- **Top module:** outstanding-vector logic, counters, watchdog and FSM.

## Test plan
- **Init delay:** INIT_DELAY=100; deassert `reset`. `init_done`=0 through edge 99 and 1 at edge 100. Pulse `drv_start` during INIT: no count.
- **Three transactions:**
  - Drivers 0, 1 and 2 start in the same cycle: `active_drv`=3, `run_busy`=1.
  - The dones arrive staggered; after the third, `passive_drv`=3, `run_done`=1 and `run_busy`=0 on the same edge.
- **Protocol errors:**
  - Done on idle driver 4: `proto_err`=1, `passive_drv` unchanged.
  - Double start on driver 2: `proto_err`=1, `active_drv` +1 only once.
- **Same-cycle start/done:** driver 5 with bit clear: both counters +1, `run_done` stays 1.
- **Watchdog:** TIMEOUT=50; one start, no done. `timeout` rises 50 cycles after the start. Then `clear`: all zeroed, `timeout`=0, state IDLE, `init_done`=1.
- **Saturation and reset:**
  - CNT_W=4: 16 start/done pairs; counters hold at 15 and `proto_err`=1.
  - Assert `reset` mid-run: all outputs are 0 the next cycle.

Source files
------------

// File: rtl/ctrl_run_tracker_pkg.sv
// Shared types, defaults and helpers for the run-control tracker.
// The popcount helper is used by the event popcount sub-module.
package ctrl_run_pkg;

   // Default parameter values for the tracker and its interface
   localparam int DEF_NUM_DRV    = 8;
   localparam int DEF_INIT_DELAY = 100;
   localparam int DEF_TIMEOUT    = 1000000;
   localparam int DEF_CNT_W      = 32;

   // Width of a per-cycle event count (up to 32 drivers -> 0..32)
   localparam int PC_W = 6;

   // Run-control states
   typedef enum logic [2:0] {
      INIT = 3'd0,
      IDLE = 3'd1,
      RUN  = 3'd2,
      DONE = 3'd3,
      TOUT = 3'd4
   } run_state_e;

   // Number of set bits in a 32-bit vector
   function automatic logic [PC_W-1:0] popcount(input logic [31:0] vec);
      logic [PC_W-1:0] acc;
      acc = 6'd0;
      for (int i = 0; i < 32; i++) begin
         acc = acc + PC_W'(vec[i]);
      end
      return acc;
   endfunction

endpackage

// File: rtl/ctrl_run_tracker_if.sv
// Control-interface bundle between the driver agents and the run tracker.
// The master side issues start/done pulses and clear; the slave reports status.
interface ctrl_run_if
   import ctrl_run_pkg::*;
#(
   parameter int NUM_DRV = DEF_NUM_DRV,
   parameter int CNT_W   = DEF_CNT_W
);
   logic [NUM_DRV-1:0] drv_start;
   logic [NUM_DRV-1:0] drv_done;
   logic               clear;
   logic               init_done;
   logic [CNT_W-1:0]   active_drv;
   logic [CNT_W-1:0]   passive_drv;
   logic               run_busy;
   logic               run_done;
   logic               timeout;
   logic               proto_err;

   modport master (
      output drv_start, drv_done, clear,
      input  init_done, active_drv, passive_drv, run_busy, run_done, timeout, proto_err
   );

   modport slave (
      input  drv_start, drv_done, clear,
      output init_done, active_drv, passive_drv, run_busy, run_done, timeout, proto_err
   );
endinterface

// File: rtl/ctrl_run_tracker_chk.sv
// Structural invariants of the run tracker's registered status outputs.
module ctrl_run_tracker_chk
   import ctrl_run_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input logic             clock,
   input logic             reset,
   input run_state_e       state,
   input logic             init_done,
   input logic             run_busy,
   input logic             run_done,
   input logic             timeout,
   input logic [CNT_W-1:0] active_drv,
   input logic [CNT_W-1:0] passive_drv
);

   a_busy_done_excl : assert property (@(posedge clock) disable iff (reset)
      !(run_busy && run_done));

   a_busy_matches : assert property (@(posedge clock) disable iff (reset)
      run_busy == (active_drv != passive_drv));

   a_timeout_state : assert property (@(posedge clock) disable iff (reset)
      timeout |-> (state == TOUT));

   a_no_count_in_init : assert property (@(posedge clock) disable iff (reset)
      !init_done |-> ((active_drv == {CNT_W{1'b0}}) && (passive_drv == {CNT_W{1'b0}}) && (state == INIT)));

endmodule

// File: rtl/ctrl_run_tracker_popcnt.sv
// Combinational count of accepted events in one cycle.
module ctrl_evt_popcnt
   import ctrl_run_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0]    evt,
   output logic [PC_W-1:0] cnt
);

   logic [31:0] vec32;

   // Zero-extend the event vector and count its set bits
   always_comb begin
      vec32        = 32'd0;
      vec32[W-1:0] = evt;
      cnt          = popcount(vec32);
   end

endmodule

// File: rtl/ctrl_run_tracker.sv
// Run-control responder: post-reset init delay, per-driver outstanding
// tracking, saturating start/done counters, run status and watchdog.
module ctrl_run_tracker
   import ctrl_run_pkg::*;
#(
   parameter int NUM_DRV    = DEF_NUM_DRV,
   parameter int INIT_DELAY = DEF_INIT_DELAY,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input logic       clock,
   input logic       reset,
   ctrl_run_if.slave bus
);

   // Sum width large enough to detect overflow past the counter ceiling
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [SUM_W-1:0] CNT_MAX_W = SUM_W'(CNT_MAX);

   run_state_e         state_q, state_d;
   logic [31:0]        dly_q, dly_d;
   logic [31:0]        idle_q, idle_d;
   logic [NUM_DRV-1:0] out_q, out_d;
   logic [CNT_W-1:0]   act_q, act_d;
   logic [CNT_W-1:0]   pas_q, pas_d;
   logic               init_done_q, init_done_d;
   logic               busy_q, busy_d;
   logic               rdone_q, rdone_d;
   logic               tout_q, tout_d;
   logic               err_q, err_d;

   logic               ev_en;
   logic [NUM_DRV-1:0] ev_mask;
   logic [NUM_DRV-1:0] acc_start;
   logic [NUM_DRV-1:0] acc_done;
   logic [NUM_DRV-1:0] viol;
   logic [NUM_DRV-1:0] out_nx;
   logic [PC_W-1:0]    pc_start;
   logic [PC_W-1:0]    pc_done;
   logic [SUM_W-1:0]   act_sum;
   logic [SUM_W-1:0]   pas_sum;
   logic [CNT_W-1:0]   act_nx;
   logic [CNT_W-1:0]   pas_nx;
   logic               init_fire;
   logic               any_evt;

   // Event acceptance: a start needs a free slot unless the same driver also
   // completes this cycle; a done needs an outstanding transaction unless the
   // same driver also starts this cycle (zero-length transaction)
   always_comb begin
      ev_en     = init_done_q & ~bus.clear;
      ev_mask   = {NUM_DRV{ev_en}};
      acc_start = bus.drv_start & ev_mask & (~out_q | bus.drv_done);
      acc_done  = bus.drv_done  & ev_mask & (out_q  | bus.drv_start);
      viol      = ev_mask & ((bus.drv_start & ~bus.drv_done & out_q) |
                             (bus.drv_done & ~bus.drv_start & ~out_q));
      out_nx    = (out_q | (acc_start & ~acc_done)) & ~(acc_done & ~acc_start);
      any_evt   = (|acc_start) | (|acc_done);
   end

   ctrl_evt_popcnt #(.W(NUM_DRV)) u_pc_start (
      .evt (acc_start),
      .cnt (pc_start)
   );

   ctrl_evt_popcnt #(.W(NUM_DRV)) u_pc_done (
      .evt (acc_done),
      .cnt (pc_done)
   );

   // Saturating next values of both event counters
   always_comb begin
      act_sum = SUM_W'(act_q) + SUM_W'(pc_start);
      pas_sum = SUM_W'(pas_q) + SUM_W'(pc_done);
      act_nx  = (act_sum > CNT_MAX_W) ? CNT_MAX : act_sum[CNT_W-1:0];
      pas_nx  = (pas_sum > CNT_MAX_W) ? CNT_MAX : pas_sum[CNT_W-1:0];
   end

   // Next-state, counter, status and watchdog logic
   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      idle_d      = idle_q;
      out_d       = out_q;
      act_d       = act_q;
      pas_d       = pas_q;
      init_done_d = init_done_q;
      busy_d      = busy_q;
      rdone_d     = rdone_q;
      tout_d      = tout_q;
      err_d       = err_q;

      // Init delay runs independently of clear so init_done is unaffected
      init_fire = (state_q == INIT) && (dly_q == 32'(INIT_DELAY - 1));
      if (state_q == INIT) begin
         if (init_fire) begin
            init_done_d = 1'b1;
         end else begin
            dly_d = dly_q + 32'd1;
         end
      end else begin
         dly_d = dly_q;
      end

      if (bus.clear) begin
         act_d   = {CNT_W{1'b0}};
         pas_d   = {CNT_W{1'b0}};
         out_d   = {NUM_DRV{1'b0}};
         err_d   = 1'b0;
         tout_d  = 1'b0;
         idle_d  = 32'd0;
         busy_d  = 1'b0;
         rdone_d = 1'b0;
         state_d = (init_done_q | init_fire) ? IDLE : INIT;
      end else begin
         act_d   = act_nx;
         pas_d   = pas_nx;
         out_d   = out_nx;
         busy_d  = (act_nx != pas_nx);
         rdone_d = (act_nx == pas_nx) && (act_nx != {CNT_W{1'b0}});
         err_d   = err_q | (|viol) | (act_nx == CNT_MAX) | (pas_nx == CNT_MAX);

         case (state_q)
            INIT: begin
               idle_d  = 32'd0;
               state_d = init_fire ? IDLE : INIT;
            end
            IDLE, DONE: begin
               idle_d  = 32'd0;
               state_d = (|acc_start) ? RUN : state_q;
            end
            RUN: begin
               if (pas_nx == act_nx) begin
                  idle_d  = 32'd0;
                  state_d = DONE;
               end else if (any_evt) begin
                  idle_d  = 32'd0;
                  state_d = RUN;
               end else if (TIMEOUT == 0) begin
                  idle_d  = idle_q;
                  state_d = RUN;
               end else if ((idle_q + 32'd1) == 32'(TIMEOUT)) begin
                  idle_d  = idle_q + 32'd1;
                  tout_d  = 1'b1;
                  state_d = TOUT;
               end else begin
                  idle_d  = idle_q + 32'd1;
                  state_d = RUN;
               end
            end
            TOUT: begin
               idle_d  = idle_q;
               state_d = TOUT;
            end
            default: begin
               idle_d  = 32'd0;
               state_d = INIT;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         dly_q       <= 32'd0;
         idle_q      <= 32'd0;
         out_q       <= {NUM_DRV{1'b0}};
         act_q       <= {CNT_W{1'b0}};
         pas_q       <= {CNT_W{1'b0}};
         init_done_q <= 1'b0;
         busy_q      <= 1'b0;
         rdone_q     <= 1'b0;
         tout_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         idle_q      <= idle_d;
         out_q       <= out_d;
         act_q       <= act_d;
         pas_q       <= pas_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         rdone_q     <= rdone_d;
         tout_q      <= tout_d;
         err_q       <= err_d;
      end
   end

   assign bus.init_done   = init_done_q;
   assign bus.active_drv  = act_q;
   assign bus.passive_drv = pas_q;
   assign bus.run_busy    = busy_q;
   assign bus.run_done    = rdone_q;
   assign bus.timeout     = tout_q;
   assign bus.proto_err   = err_q;

   ctrl_run_tracker_chk #(.CNT_W(CNT_W)) u_chk (
      .clock       (clock),
      .reset       (reset),
      .state       (state_q),
      .init_done   (init_done_q),
      .run_busy    (busy_q),
      .run_done    (rdone_q),
      .timeout     (tout_q),
      .active_drv  (act_q),
      .passive_drv (pas_q)
   );

endmodule

// File: tb/tb_ctrl_run_tracker.sv
// Scoreboard bench for ctrl_run_tracker: directed scenarios plus random
// start/done traffic, checked against a behavioural model of the run rules.
module tb_ctrl_run_tracker;

   localparam int ND   = 8;
   localparam int ID   = 100;
   localparam int TO   = 50;
   localparam int CW   = 4;
   localparam int MAXC = 15;

   localparam int M_INIT = 0;
   localparam int M_IDLE = 1;
   localparam int M_RUN  = 2;
   localparam int M_DONE = 3;
   localparam int M_TOUT = 4;

   typedef struct {
      int            edge_no;
      logic          init_done;
      logic [CW-1:0] act;
      logic [CW-1:0] pas;
      logic          busy;
      logic          rdone;
      logic          tout;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];

   // Behavioural model state
   int m_cyc;
   bit m_init;
   bit m_out[ND];
   int m_act, m_pas;
   bit m_err, m_tout;
   int m_mode;
   int m_idle;

   ctrl_run_if #(.NUM_DRV(ND), .CNT_W(CW)) bus ();

   ctrl_run_tracker #(
      .NUM_DRV    (ND),
      .INIT_DELAY (ID),
      .TIMEOUT    (TO),
      .CNT_W      (CW)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Apply one cycle of stimulus, advance the model, queue the expectation
   task automatic step(input bit r, input logic [ND-1:0] st, input logic [ND-1:0] dn, input bit cl);
      exp_t e;
      int   na, np;
      bit   viol, was_init;
      rst           = r;
      bus.drv_start = st;
      bus.drv_done  = dn;
      bus.clear     = cl;
      if (r) begin
         m_cyc = 0; m_init = 0; m_act = 0; m_pas = 0;
         m_err = 0; m_tout = 0; m_mode = M_INIT; m_idle = 0;
         for (int i = 0; i < ND; i++) m_out[i] = 0;
      end else begin
         was_init = m_init;
         m_cyc++;
         if (m_cyc == ID) m_init = 1;
         if (cl) begin
            m_act = 0; m_pas = 0; m_err = 0; m_tout = 0; m_idle = 0;
            for (int i = 0; i < ND; i++) m_out[i] = 0;
            m_mode = m_init ? M_IDLE : M_INIT;
         end else if (was_init) begin
            na = 0; np = 0; viol = 0;
            for (int i = 0; i < ND; i++) begin
               if (st[i] && dn[i]) begin
                  na++; np++;
               end else if (st[i]) begin
                  if (m_out[i]) viol = 1;
                  else begin na++; m_out[i] = 1; end
               end else if (dn[i]) begin
                  if (!m_out[i]) viol = 1;
                  else begin np++; m_out[i] = 0; end
               end
            end
            m_act = (m_act + na > MAXC) ? MAXC : m_act + na;
            m_pas = (m_pas + np > MAXC) ? MAXC : m_pas + np;
            if (viol || m_act == MAXC || m_pas == MAXC) m_err = 1;
            if (m_mode == M_IDLE || m_mode == M_DONE) begin
               m_idle = 0;
               if (na > 0) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
               if (m_act == m_pas) begin
                  m_mode = M_DONE; m_idle = 0;
               end else if (na + np > 0) begin
                  m_idle = 0;
               end else begin
                  m_idle++;
                  if (m_idle == TO) begin m_mode = M_TOUT; m_tout = 1; end
               end
            end
         end else if (m_init) begin
            m_mode = M_IDLE;
         end
      end
      e.edge_no   = edge_cnt + 1;
      e.init_done = m_init;
      e.act       = CW'(m_act);
      e.pas       = CW'(m_pas);
      e.busy      = (m_act != m_pas);
      e.rdone     = (m_act == m_pas) && (m_act != 0);
      e.tout      = m_tout;
      e.err       = m_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   function automatic logic [ND-1:0] sparse();
      return 8'($urandom) & 8'($urandom) & 8'($urandom);
   endfunction

   // Monitor: compare every DUT output cycle with the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.init_done === e.init_done && bus.active_drv === e.act &&
                bus.passive_drv === e.pas && bus.run_busy === e.busy &&
                bus.run_done === e.rdone && bus.timeout === e.tout &&
                bus.proto_err === e.err) begin
               n_pass++;
            end else begin
               $display("FAIL status@edge%0d: got init=%b act=%0d pas=%0d busy=%b done=%b tout=%b err=%b, want init=%b act=%0d pas=%0d busy=%b done=%b tout=%b err=%b",
                        e.edge_no, bus.init_done, bus.active_drv, bus.passive_drv, bus.run_busy,
                        bus.run_done, bus.timeout, bus.proto_err, e.init_done, e.act, e.pas,
                        e.busy, e.rdone, e.tout, e.err);
            end
         end
      end
   end

   // Stimulus: directed scenarios, random traffic, mid-run reset
   initial begin
      int wait_cyc;
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 8'h00, 1'b0);

      // Init window: starts here must be ignored, including on edge ID
      for (int i = 1; i < ID; i++) step(1'b0, ($urandom_range(0, 7) == 0) ? sparse() : 8'h00, 8'h00, 1'b0);
      step(1'b0, 8'h01, 8'h00, 1'b0);

      // Three transactions, staggered completions
      step(1'b0, 8'h07, 8'h00, 1'b0);
      idle(2);
      step(1'b0, 8'h00, 8'h01, 1'b0);
      idle(1);
      step(1'b0, 8'h00, 8'h02, 1'b0);
      step(1'b0, 8'h00, 8'h04, 1'b0);

      // Protocol errors: done on idle driver, double start
      step(1'b0, 8'h00, 8'h10, 1'b0);
      step(1'b0, 8'h04, 8'h00, 1'b0);
      step(1'b0, 8'h04, 8'h00, 1'b0);
      step(1'b0, 8'h00, 8'h04, 1'b0);

      // Zero-length transaction on driver 5
      step(1'b0, 8'h20, 8'h20, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      idle(1);

      // Watchdog: a start with no done, then clear
      step(1'b0, 8'h08, 8'h00, 1'b0);
      idle(55);
      step(1'b0, 8'h00, 8'h00, 1'b1);
      idle(2);

      // Saturation: 16 start/done pairs on driver 0
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h01, 8'h00, 1'b0);
         step(1'b0, 8'h00, 8'h01, 1'b0);
      end
      step(1'b0, 8'h00, 8'h00, 1'b1);

      // Random traffic with occasional clears, including clear+events
      for (int i = 0; i < 300; i++)
         step(1'b0, sparse(), sparse(), ($urandom_range(0, 39) == 0));

      // Reset mid-run, then a fresh init window and more traffic
      step(1'b0, 8'h03, 8'h00, 1'b0);
      step(1'b1, 8'hFF, 8'hFF, 1'b0);
      for (int i = 0; i < ID + 60; i++)
         step(1'b0, sparse(), sparse(), ($urandom_range(0, 49) == 0));
      idle(2);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
